apb_arbiter: RTL

APB_ARBITER -- requirements
Module: apb_arbiter

---
 rtl/apb_arb_pkg.sv | 29 ++
 rtl/apb_rr_arbiter.sv | 29 ++
 rtl/apb_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and constants for the two-master APB arbiter.
//   arb_state_t   : bus-side phase (IDLE / SETUP / ACCESS)
//   mst_idx_t     : 1-bit master index (0 = master 0, 1 = master 1)
//   cnt_width()   : width of the ACCESS timeout counter for a given limit
// -----------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } arb_state_t;

    typedef logic mst_idx_t;

    localparam mst_idx_t MST0 = 1'b0;
    localparam mst_idx_t MST1 = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd255;
    localparam int unsigned TIMEOUT_MAX     = 32'd1023;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 32'd1);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Two-way round-robin tie-break. A lone requester always wins; when both
// request, the master that was not granted last wins.
// Ports:
//   req[1:0] : request vector (bit n = master n)
//   last     : index of the master granted most recently
//   gnt      : index of the winning master (MST0 when nobody requests)
// -----------------------------------------------------------------------------
module apb_rr_arbiter
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   last,
    output mst_idx_t   gnt
);

    // Winner selection
    always_comb begin
        gnt = MST0;
        case (req)
            2'b01:   gnt = MST0;
            2'b10:   gnt = MST1;
            2'b11:   gnt = ~last;
            default: gnt = MST0;
        endcase
    end

endmodule

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Arbitrates two APB masters onto one shared APB slave port. The bus-side
// phase (IDLE/SETUP/ACCESS) is generated here; master-side penable is ignored.
// Ports:
//   clock, reset (async, active-low)
//   m0_* / m1_* : APB requests in (paddr/psel/penable/pprot/pwrite/pwdata/pstrb)
//                 and responses out (pready/prdata/pslverr)
//   out_*       : APB request to the shared slave and its response back
// Parameter:
//   TIMEOUT     : ACCESS cycles without pready before forced termination
//                 (legal 1..1023)
// Build option:
//   APB_ARB_TIMEOUT_EN : when defined, a stalled ACCESS is terminated after
//                        TIMEOUT wait cycles with pready=1, pslverr=1, prdata=0
//                        to the granted master. When undefined, ACCESS waits
//                        indefinitely.
// -----------------------------------------------------------------------------
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_paddr,
    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic [2:0]  m0_pprot,
    input  logic        m0_pwrite,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    output logic        m0_pready,
    output logic [31:0] m0_prdata,
    output logic        m0_pslverr,

    input  logic [31:0] m1_paddr,
    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic [2:0]  m1_pprot,
    input  logic        m1_pwrite,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    output logic        m1_pready,
    output logic [31:0] m1_prdata,
    output logic        m1_pslverr,

    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    if ((TIMEOUT < 32'd1) || (TIMEOUT > TIMEOUT_MAX)) begin : g_timeout_range
        $error("apb_arbiter: TIMEOUT must be within 1..1023");
    end

    arb_state_t  state_r;
    arb_state_t  state_nxt_s;
    mst_idx_t    grant_r;       // master owning the current transfer
    mst_idx_t    last_r;        // master that completed most recently
    mst_idx_t    rr_gnt_s;
    logic        any_req_s;
    logic        done_s;        // transfer ends this cycle (slave or timeout)
    logic        timeout_hit_s;
    logic        rsp_ready_s;
    logic [31:0] rsp_data_s;
    logic        rsp_err_s;
    logic        unused_penable_s;

    // Master-side penable carries no information for the arbiter.
    assign unused_penable_s = m0_penable ^ m1_penable;

    assign any_req_s = m0_psel | m1_psel;
    assign done_s    = (state_r == ST_ACCESS) && (out_pready || timeout_hit_s);

    apb_rr_arbiter u_rr (
        .req  ({m1_psel, m0_psel}),
        .last (last_r),
        .gnt  (rr_gnt_s)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] to_cnt_r;

    // The slave response wins over a timeout landing on the same cycle.
    assign timeout_hit_s = (state_r == ST_ACCESS) && !out_pready &&
                           (to_cnt_r == CNT_W'(TIMEOUT));

    // Wait-cycle counter: zero outside ACCESS, so it starts at 0 on entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_ACCESS) begin
            to_cnt_r <= {CNT_W{1'b0}};
        end else if (!out_pready && !timeout_hit_s) begin
            to_cnt_r <= to_cnt_r + CNT_W'(1'b1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Phase register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant capture on IDLE->SETUP; last-grant update on completion.
    // last_r resets to master 1 so that master 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_r <= MST0;
            last_r  <= MST1;
        end else begin
            if ((state_r == ST_IDLE) && any_req_s) begin
                grant_r <= rr_gnt_s;
            end else begin
                grant_r <= grant_r;
            end
            if (done_s) begin
                last_r <= grant_r;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Next-phase logic; illegal encodings fall back to IDLE
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Slave-side request mux and response selection for the granted master
    always_comb begin
        out_psel    = 1'b0;
        out_penable = 1'b0;
        out_paddr   = 32'h0000_0000;
        out_pprot   = 3'b000;
        out_pwrite  = 1'b0;
        out_pwdata  = 32'h0000_0000;
        out_pstrb   = 4'b0000;
        rsp_ready_s = 1'b0;
        rsp_data_s  = 32'h0000_0000;
        rsp_err_s   = 1'b0;
        if ((state_r == ST_SETUP) || (state_r == ST_ACCESS)) begin
            // A forced termination drops the slave select on its own cycle.
            out_psel    = !timeout_hit_s;
            out_penable = (state_r == ST_ACCESS) && !timeout_hit_s;
            if (grant_r == MST1) begin
                out_paddr  = m1_paddr;
                out_pprot  = m1_pprot;
                out_pwrite = m1_pwrite;
                out_pwdata = m1_pwdata;
                out_pstrb  = m1_pstrb;
            end else begin
                out_paddr  = m0_paddr;
                out_pprot  = m0_pprot;
                out_pwrite = m0_pwrite;
                out_pwdata = m0_pwdata;
                out_pstrb  = m0_pstrb;
            end
        end else begin
            out_psel = 1'b0;
        end
        if (state_r == ST_ACCESS) begin
            if (timeout_hit_s) begin
                rsp_ready_s = 1'b1;
                rsp_data_s  = 32'h0000_0000;
                rsp_err_s   = 1'b1;
            end else begin
                rsp_ready_s = out_pready;
                rsp_data_s  = out_prdata;
                rsp_err_s   = out_pslverr;
            end
        end else begin
            rsp_ready_s = 1'b0;
        end
    end

    // Response routing: only the granted master ever sees a non-zero response
    always_comb begin
        m0_pready  = 1'b0;
        m0_prdata  = 32'h0000_0000;
        m0_pslverr = 1'b0;
        m1_pready  = 1'b0;
        m1_prdata  = 32'h0000_0000;
        m1_pslverr = 1'b0;
        if (grant_r == MST1) begin
            m1_pready  = rsp_ready_s;
            m1_prdata  = rsp_data_s;
            m1_pslverr = rsp_err_s;
        end else begin
            m0_pready  = rsp_ready_s;
            m0_prdata  = rsp_data_s;
            m0_pslverr = rsp_err_s;
        end
    end

endmodule
